// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests to the
// instruction memory, and buffers returned words in a small prefetch FIFO for decode.
module riscv_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_hazard_stallF,
    input  logic            i_redirectE,
    input  logic [XLEN-1:0] i_redirect_pcE,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F,
    output logic            o_fetch_emptyF
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] reqPc;
    logic [XLEN-1:0] respPc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dropCnt;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [XLEN-1:0] fifoPc    [FIFO_DEPTH];
    logic [XLEN-1:0] fifoInstr [FIFO_DEPTH];

    logic [CW:0] inFlight;
    logic        fire;
    logic        push;
    logic        pop;
    logic        notEmpty;

    // Every buffered word plus every in-flight request holds one FIFO slot,
    // so a response can always be accepted without overflow.
    assign inFlight    = {1'b0, outstanding} + {1'b0, count};
    assign o_imem_req  = !i_rst && !i_redirectE && (inFlight < CREDITS);
    assign o_imem_addr = reqPc;

    assign fire     = o_imem_req && i_imem_gnt;
    assign notEmpty = (count != '0);
    assign push     = i_imem_rvalid && (dropCnt == '0) && !i_redirectE;
    assign pop      = notEmpty && !i_hazard_stallF && !i_redirectE;

    assign o_fetch_emptyF = i_rst || !notEmpty;
    assign o_instrF       = o_fetch_emptyF ? NOP : fifoInstr[rdPtr];
    assign o_PCF          = i_rst ? RESET_PC : (notEmpty ? fifoPc[rdPtr] : respPc);
    assign o_PCPlus4F     = o_PCF + XLEN'(4);

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifoPc[wrPtr]    <= respPc;
            fifoInstr[wrPtr] <= i_imem_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && i_imem_rvalid) begin
            assert (outstanding != '0);
        end
        if (i_rst) begin
            reqPc       <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else if (i_redirectE) begin
            // All in-flight responses become stale; outstanding already
            // includes any drops still pending from an earlier redirect.
            reqPc       <= i_redirect_pcE;
            respPc      <= i_redirect_pcE;
            outstanding <= outstanding - CW'(i_imem_rvalid);
            dropCnt     <= outstanding - CW'(i_imem_rvalid);
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else begin
            if (fire) begin
                reqPc <= reqPc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(fire) - CW'(i_imem_rvalid);
            if (i_imem_rvalid && (dropCnt != '0)) begin
                dropCnt <= dropCnt - CW'(1);
            end
            if (push) begin
                respPc <= respPc + XLEN'(4);
                wrPtr  <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: a latency-configurable imem model answers
// granted requests with addr^A5A5A5A5, and each cycle is checked against a vector.
module tb_riscv_fetch;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        gnt;
        int          lat;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expEmpty;
        logic [31:0] expPc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        empty;

    int    cyc = 0;
    int    lat = 1;
    resp_t pend[$];
    vec_t  rows[$];
    int    passCount = 0;
    int    checkCount = 0;

    riscv_fetch dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hazard_stallF(stall),
        .i_redirectE    (redir),
        .i_redirect_pcE (target),
        .o_imem_req     (req),
        .o_imem_addr    (addr),
        .i_imem_gnt     (gnt),
        .i_imem_rvalid  (rvalid),
        .i_imem_rdata   (rdata),
        .o_instrF       (instr),
        .o_PCF          (pc),
        .o_PCPlus4F     (pcPlus4),
        .o_fetch_emptyF (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // In-order memory: a granted request answers lat cycles later.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (rvalid) void'(pend.pop_front());
            if (req && gnt) pend.push_back('{addr, cyc + lat});
        end
        cyc++;
    end

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] t,
                                input logic g, input int l, input logic eReq, input logic [31:0] eAddr,
                                input logic eEmpty, input logic [31:0] ePc);
        vec_t v;
        v = '{r, s, d, t, g, l, eReq, eAddr, eEmpty, ePc};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst    = v.rst;
        stall  = v.stall;
        redir  = v.redir;
        target = v.target;
        gnt    = v.gnt;
        lat    = v.lat;
        if (!v.rst && pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = pend[0].addr ^ 32'hA5A5_A5A5;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        #1;
    endtask

    task automatic checkOne(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        logic [31:0] expInstr;
        expInstr = v.expEmpty ? 32'h0000_0013 : (v.expPc ^ 32'hA5A5_A5A5);
        checkOne(name, "req",   {31'b0, req},   {31'b0, v.expReq});
        checkOne(name, "addr",  addr,           v.expAddr);
        checkOne(name, "empty", {31'b0, empty}, {31'b0, v.expEmpty});
        checkOne(name, "pc",    pc,             v.expPc);
        checkOne(name, "pc4",   pcPlus4,        v.expPc + 32'd4);
        checkOne(name, "instr", instr,          expInstr);
    endtask

    task automatic runStep(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; target = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;

        // Zero-wait memory, then a 5-cycle stall with the FIFO filling up.
        rows.push_back(mk(1,0,0,0,1,1, 0,32'h00,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h00,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h04,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,1, 0,32'h08,0,32'h00));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h08,0,32'h04));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h0C,1,32'h08));
        rows.push_back(mk(0,0,0,0,1,1, 0,32'h10,0,32'h08));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h10,0,32'h0C));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h14,1,32'h10));
        for (int i = 0; i < 5; i++) rows.push_back(mk(0,1,0,0,1,1, 0,32'h18,0,32'h10));
        rows.push_back(mk(0,0,0,0,1,1, 0,32'h18,0,32'h10));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h18,0,32'h14));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h1C,1,32'h18));
        rows.push_back(mk(0,0,0,0,1,1, 0,32'h20,0,32'h18));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h20,0,32'h1C));
        // Latency 3, redirect to 0x200 with two requests in flight.
        rows.push_back(mk(1,0,0,0,1,3, 0,32'h24,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,3, 1,32'h00,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,3, 1,32'h04,1,32'h00));
        rows.push_back(mk(0,0,1,32'h200,1,3, 0,32'h08,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,3, 0,32'h200,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,3, 1,32'h200,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,3, 1,32'h204,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,3, 0,32'h208,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,3, 0,32'h208,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,3, 0,32'h208,0,32'h200));
        rows.push_back(mk(0,0,0,0,1,3, 1,32'h208,0,32'h204));
        // Latency 2, redirect coinciding with an rvalid, one more in flight.
        rows.push_back(mk(1,0,0,0,1,2, 0,32'h20C,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,2, 1,32'h00,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,2, 1,32'h04,1,32'h00));
        rows.push_back(mk(0,0,1,32'h200,1,2, 0,32'h08,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,2, 1,32'h200,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,2, 1,32'h204,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,2, 0,32'h208,1,32'h200));
        rows.push_back(mk(0,0,0,0,1,2, 0,32'h208,0,32'h200));
        rows.push_back(mk(0,0,0,0,1,2, 1,32'h208,0,32'h204));
        rows.push_back(mk(0,0,0,0,1,2, 1,32'h20C,1,32'h208));
        // Grant withheld for 4 cycles, then bubbles while gnt is low again.
        rows.push_back(mk(1,0,0,0,0,1, 0,32'h210,1,32'h00));
        for (int i = 0; i < 4; i++) rows.push_back(mk(0,0,0,0,0,1, 1,32'h00,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h00,1,32'h00));
        rows.push_back(mk(0,0,0,0,1,1, 1,32'h04,1,32'h00));
        rows.push_back(mk(0,0,0,0,0,1, 0,32'h08,0,32'h00));
        rows.push_back(mk(0,0,0,0,0,1, 1,32'h08,0,32'h04));
        rows.push_back(mk(0,0,0,0,0,1, 1,32'h08,1,32'h08));
        rows.push_back(mk(0,0,0,0,0,1, 1,32'h08,1,32'h08));

        foreach (rows[i]) runStep($sformatf("row%0d", i), rows[i]);

        // Reset with the FIFO full under stall.
        runStep("fullRst0", mk(1,0,0,0,0,1, 0,32'h08,1,32'h00));
        runStep("fullRst1", mk(0,1,0,0,1,1, 1,32'h00,1,32'h00));
        runStep("fullRst2", mk(0,1,0,0,1,1, 1,32'h04,1,32'h00));
        runStep("fullRst3", mk(0,1,0,0,1,1, 0,32'h08,0,32'h00));
        runStep("fullRst4", mk(0,1,0,0,1,1, 0,32'h08,0,32'h00));
        runStep("fullRst5", mk(1,0,0,0,0,3, 0,32'h08,1,32'h00));
        // Reset with two requests outstanding.
        runStep("outRst0", mk(0,0,0,0,1,3, 1,32'h00,1,32'h00));
        runStep("outRst1", mk(0,0,0,0,1,3, 1,32'h04,1,32'h00));
        runStep("outRst2", mk(1,0,0,0,0,3, 0,32'h08,1,32'h00));
        runStep("outRst3", mk(0,0,0,0,0,3, 1,32'h00,1,32'h00));
        // Back-to-back redirects: the second target wins.
        runStep("b2b0", mk(0,0,0,0,1,1, 1,32'h00,1,32'h00));
        runStep("b2b1", mk(0,0,1,32'h100,1,1, 0,32'h04,1,32'h00));
        runStep("b2b2", mk(0,0,1,32'h300,1,1, 0,32'h100,1,32'h100));
        runStep("b2b3", mk(0,0,0,0,1,1, 1,32'h300,1,32'h300));
        runStep("b2b4", mk(0,0,0,0,1,1, 1,32'h304,1,32'h300));
        runStep("b2b5", mk(0,0,0,0,1,1, 0,32'h308,0,32'h300));
        runStep("b2b6", mk(0,0,0,0,0,1, 1,32'h308,0,32'h304));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
